// File: rtl/fir_pkg.sv
// Shared defaults and index helpers for the FIR sample-history datapath.
package fir_pkg;

  localparam int unsigned DataWDef = 8;
  localparam int unsigned TapsDef  = 5;
  localparam int unsigned ChDef    = 1;

  function automatic int unsigned ch_width(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // (p - k) mod n for p < n and k <= n, valid for any n.
  function automatic int unsigned mod_dec(input int unsigned p, input int unsigned k,
                                          input int unsigned n);
    int unsigned s;
    s = p + n - k;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/fir_tap_ring.sv
// One channel's circular sample ring with fill tracking; window is age-ordered, tap 0 newest.
module fir_tap_ring
  import fir_pkg::*;
#(
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned Taps  = TapsDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  wr_en_i,
  input  logic [DataW-1:0]      wr_data_i,
  output logic [Taps*DataW-1:0] taps_o,
  output logic                  primed_o
);

  localparam int unsigned PtrW = $clog2(Taps);
  localparam int unsigned FcW  = $clog2(Taps + 1);

  logic [DataW-1:0] mem_q [Taps];
  logic [PtrW-1:0]  wp_q, wp_d;
  logic [FcW-1:0]   fc_q, fc_d;

  always_comb begin
    wp_d = (wp_q == PtrW'(Taps - 1)) ? '0 : wp_q + PtrW'(1);
    fc_d = (fc_q == FcW'(Taps)) ? fc_q : fc_q + FcW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Taps; i++) mem_q[i] <= '0;
      wp_q <= '0;
      fc_q <= '0;
    end else if (clear_i) begin
      for (int i = 0; i < Taps; i++) mem_q[i] <= '0;
      wp_q <= '0;
      fc_q <= '0;
    end else if (wr_en_i) begin
      mem_q[wp_q] <= wr_data_i;
      wp_q        <= wp_d;
      fc_q        <= fc_d;
    end
  end

  // wp_q points one past the newest entry, so tap k lives k+1 slots behind it.
  always_comb begin
    taps_o = '0;
    for (int k = 0; k < Taps; k++) begin
      taps_o[k*DataW +: DataW] = mem_q[PtrW'(mod_dec(int'(wp_q), k + 1, Taps))];
    end
  end

  assign primed_o = (fc_q == FcW'(Taps));

endmodule

// File: rtl/fir_tap_buffer.sv
// Multi-channel FIR tap history: per-channel rings, channel demux, registered window output.
module fir_tap_buffer
  import fir_pkg::*;
#(
  parameter int unsigned DataW = DataWDef,
  parameter int unsigned Taps  = TapsDef,
  parameter int unsigned Ch    = ChDef,
  parameter int unsigned ChW   = ch_width(Ch)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  in_valid_i,
  input  logic [ChW-1:0]        in_ch_i,
  input  logic [DataW-1:0]      in_data_i,
  output logic                  out_valid_o,
  output logic [ChW-1:0]        out_ch_o,
  output logic [Taps*DataW-1:0] out_taps_o,
  output logic                  out_primed_o
);

  logic                  accept;
  logic [Ch-1:0]         wr_en;
  logic [Taps*DataW-1:0] ring_taps [Ch];
  logic [Ch-1:0]         ring_primed;

  logic                  pend_valid_q;
  logic [ChW-1:0]        pend_ch_q;
  logic [Taps*DataW-1:0] sel_taps;
  logic                  sel_primed;
  logic                  out_valid_d;

  logic                  out_valid_q;
  logic [ChW-1:0]        out_ch_q;
  logic [Taps*DataW-1:0] out_taps_q;
  logic                  out_primed_q;

  assign accept = in_valid_i & ~clear_i & (32'(in_ch_i) < Ch);

  for (genvar c = 0; c < Ch; c++) begin : g_ring
    assign wr_en[c] = accept & (in_ch_i == ChW'(c));

    fir_tap_ring #(
      .DataW(DataW),
      .Taps (Taps)
    ) u_ring (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear_i  (clear_i),
      .wr_en_i  (wr_en[c]),
      .wr_data_i(in_data_i),
      .taps_o   (ring_taps[c]),
      .primed_o (ring_primed[c])
    );
  end

  always_comb begin
    sel_taps   = ring_taps[0];
    sel_primed = ring_primed[0];
    for (int c = 0; c < Ch; c++) begin
      if (pend_ch_q == ChW'(c)) begin
        sel_taps   = ring_taps[c];
        sel_primed = ring_primed[c];
      end
    end
    // A clear landing while a window is pending also drops that window.
    out_valid_d = pend_valid_q & ~clear_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_ch_q    <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_taps_q   <= '0;
      out_primed_q <= 1'b0;
    end else begin
      pend_valid_q <= accept;
      if (accept) pend_ch_q <= in_ch_i;
      out_valid_q <= out_valid_d;
      if (out_valid_d) begin
        out_ch_q     <= pend_ch_q;
        out_taps_q   <= sel_taps;
        out_primed_q <= sel_primed;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_ch_o     = out_ch_q;
  assign out_taps_o   = out_taps_q;
  assign out_primed_o = out_primed_q;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Scoreboard bench: three configurations (defaults, CH=3, TAPS=7/DATA_W=12) with directed vectors.
module tb_fir_tap_buffer;

  typedef struct {
    logic [1:0]  ch;
    logic        primed;
    logic [83:0] taps;
  } exp_t;

  logic clk;
  logic rst_n, rst_nc;

  logic        clear_a, v_a, ov_a, op_a;
  logic [0:0]  ch_a, och_a;
  logic [7:0]  d_a;
  logic [39:0] ot_a;

  logic        clear_b, v_b, ov_b, op_b;
  logic [1:0]  ch_b, och_b;
  logic [7:0]  d_b;
  logic [39:0] ot_b;

  logic        clear_c, v_c, ov_c, op_c;
  logic [0:0]  ch_c, och_c;
  logic [11:0] d_c;
  logic [83:0] ot_c;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int n_vec = 0;
  int n_bad = 0;

  fir_tap_buffer u_dut_a (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_a), .in_valid_i(v_a), .in_ch_i(ch_a),
    .in_data_i(d_a), .out_valid_o(ov_a), .out_ch_o(och_a), .out_taps_o(ot_a),
    .out_primed_o(op_a)
  );

  fir_tap_buffer #(.Ch(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_b), .in_valid_i(v_b), .in_ch_i(ch_b),
    .in_data_i(d_b), .out_valid_o(ov_b), .out_ch_o(och_b), .out_taps_o(ot_b),
    .out_primed_o(op_b)
  );

  fir_tap_buffer #(.DataW(12), .Taps(7)) u_dut_c (
    .clk(clk), .rst_n(rst_nc), .clear_i(clear_c), .in_valid_i(v_c), .in_ch_i(ch_c),
    .in_data_i(d_c), .out_valid_o(ov_c), .out_ch_o(och_c), .out_taps_o(ot_c),
    .out_primed_o(op_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [87:0] got, input logic [87:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [83:0] pk5(input int t0, input int t1, input int t2, input int t3,
                                      input int t4);
    return 84'(t0) | (84'(t1) << 8) | (84'(t2) << 16) | (84'(t3) << 24) | (84'(t4) << 32);
  endfunction

  // Window after samples 1..newest on one channel, zero-padded where not yet written.
  function automatic logic [83:0] ramp(input int dw, input int taps, input int newest);
    logic [83:0] r;
    r = '0;
    for (int k = 0; k < taps; k++) begin
      if (newest - k > 0) r = r | (84'(newest - k) << (k * dw));
    end
    return r;
  endfunction

  task automatic send(input int which, input int ch, input int data, input bit clr);
    case (which)
      0: begin v_a = 1'b1; ch_a = 1'(ch); d_a = 8'(data);  clear_a = clr; end
      1: begin v_b = 1'b1; ch_b = 2'(ch); d_b = 8'(data);  clear_b = clr; end
      default: begin v_c = 1'b1; ch_c = 1'(ch); d_c = 12'(data); clear_c = clr; end
    endcase
    @(posedge clk);
    #1;
    v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
    clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
  endtask

  always @(negedge clk) begin
    if (ov_a) begin
      if (qa.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL mon_a: unexpected out_valid, taps %h", ot_a);
      end else begin
        ea = qa.pop_front();
        check("win_a", {2'(och_a), 1'b1, op_a, 84'(ot_a)}, {ea.ch, 1'b1, ea.primed, ea.taps});
      end
    end
  end

  always @(negedge clk) begin
    if (ov_b) begin
      if (qb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL mon_b: unexpected out_valid, ch %0d taps %h", och_b, ot_b);
      end else begin
        eb = qb.pop_front();
        check("win_b", {och_b, 1'b1, op_b, 84'(ot_b)}, {eb.ch, 1'b1, eb.primed, eb.taps});
      end
    end
  end

  always @(negedge clk) begin
    if (ov_c) begin
      if (qc.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL mon_c: unexpected out_valid, taps %h", ot_c);
      end else begin
        ec = qc.pop_front();
        check("win_c", {2'(och_c), 1'b1, op_c, ot_c}, {ec.ch, 1'b1, ec.primed, ec.taps});
      end
    end
  end

  initial begin
    rst_n = 1'b0; rst_nc = 1'b0;
    clear_a = 1'b0; v_a = 1'b0; ch_a = '0; d_a = '0;
    clear_b = 1'b0; v_b = 1'b0; ch_b = '0; d_b = '0;
    clear_c = 1'b0; v_c = 1'b0; ch_c = '0; d_c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a", {2'(och_a), ov_a, op_a, 84'(ot_a)}, '0);
    check("rst_b", {och_b, ov_b, op_b, 84'(ot_b)}, '0);
    check("rst_c", {2'(och_c), ov_c, op_c, ot_c}, '0);
    rst_n = 1'b1; rst_nc = 1'b1;

    // Fill and wrap on defaults: samples 1..12, primed from the 5th on.
    for (int i = 1; i <= 12; i++) begin
      qa.push_back('{2'd0, 1'(i >= 5), ramp(8, 5, i)});
      send(0, 0, i, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    // Clear collides with a sample: sample dropped, history flushed.
    send(0, 0, 99, 1'b1);
    qa.push_back('{2'd0, 1'b0, pk5(7, 0, 0, 0, 0)});
    send(0, 0, 7, 1'b0);

    // Interleaved channels, back to back.
    qb.push_back('{2'd0, 1'b0, pk5(10, 0, 0, 0, 0)});  send(1, 0, 10, 1'b0);
    qb.push_back('{2'd1, 1'b0, pk5(20, 0, 0, 0, 0)});  send(1, 1, 20, 1'b0);
    qb.push_back('{2'd0, 1'b0, pk5(11, 10, 0, 0, 0)}); send(1, 0, 11, 1'b0);
    qb.push_back('{2'd2, 1'b0, pk5(30, 0, 0, 0, 0)});  send(1, 2, 30, 1'b0);
    qb.push_back('{2'd0, 1'b0, pk5(12, 11, 10, 0, 0)}); send(1, 0, 12, 1'b0);
    // Out-of-range channel must be ignored entirely.
    send(1, 3, 55, 1'b0);
    repeat (3) @(negedge clk);
    check("inv_ch_valid", 88'(ov_b), '0);
    @(posedge clk);
    #1;
    qb.push_back('{2'd1, 1'b0, pk5(21, 20, 0, 0, 0)});   send(1, 1, 21, 1'b0);
    qb.push_back('{2'd0, 1'b0, pk5(13, 12, 11, 10, 0)}); send(1, 0, 13, 1'b0);
    qb.push_back('{2'd2, 1'b0, pk5(31, 30, 0, 0, 0)});   send(1, 2, 31, 1'b0);

    // TAPS=7, DATA_W=12: nine samples, then async reset between edges.
    for (int i = 1; i <= 9; i++) begin
      qc.push_back('{2'd0, 1'(i >= 7), ramp(12, 7, i)});
      send(2, 0, i, 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    #1 rst_nc = 1'b0;
    #1 check("async_rst_c", {2'(och_c), ov_c, op_c, ot_c}, '0);
    #1 rst_nc = 1'b1;
    @(posedge clk);
    #1;
    qc.push_back('{2'd0, 1'b0, 84'h000_0000_0000_0000_0ABC});
    send(2, 0, 'hABC, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("drain_a", 88'(qa.size()), '0);
    check("drain_b", 88'(qb.size()), '0);
    check("drain_c", 88'(qc.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_tap_buffer.md
# fir_tap_buffer

Parametrised multi-channel sample history buffer for the FIR datapath: stores the most recent TAPS samples of each of CH interleaved input channels in per-channel circular rings. On every accepted sample it presents the full window of that channel, age-ordered (tap 0 = newest), to the MAC stage one cycle later. It sits between the sample source and the coefficient multiply/accumulate tree. It replaces fixed 5-tap storage with correct non-power-of-two wrap, per-channel fill tracking, validity signalling and a synchronous clear.

## Interface
- DATA_W, 8: sample width in bits.
- TAPS, 5: window depth per channel, ≥2, need not be a power of two.
- CH, 1: number of interleaved channels, ≥1.
- CH_W, max(1,$clog2(CH)): derived channel-index width, not overridden.

- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush of all channels.
- in_valid  in  1  sample present this cycle; no backpressure, accepted every cycle.
- in_ch  in  CH_W  channel of in_data; values ≥CH ignored (sample dropped).
- in_data  in  DATA_W  sample.
- out_valid  out  1  window on out_taps valid, one-cycle pulse per accepted sample.
- out_ch  out  CH_W  channel of the presented window.
- out_taps  out  TAPS*DATA_W  window; bits [k*DATA_W +: DATA_W] = sample k positions old (k=0 newest).
- out_primed  out  1  presented channel has received ≥TAPS samples since reset/clear.

## Operation
- Per channel: ring storage TAPS×DATA_W, write pointer wp (0..TAPS-1), fill count fc (0..TAPS, saturating).
- Accepted sample (in_valid & in_ch<CH & !clear): ring[in_ch][wp] ← in_data; wp ← (wp==TAPS-1) ? 0 : wp+1; fc ← min(fc+1, TAPS). Other channels untouched.
- Window for channel c after a write at index p: tap k = ring[c][(p−k) mod TAPS], computed without a power-of-two assumption.
- Unwritten entries read as zero (storage zeroed by reset and clear), so a partially filled window is zero-padded in the oldest taps.
- out_primed = (fc of out_ch, after the write) == TAPS.
- clear: zeroes all rings, wp, fc; forces out_valid=0 next cycle. clear and in_valid together: clear wins, sample dropped.
- Invalid in_ch: no state change, out_valid=0 next cycle.
- Arithmetic: no arithmetic on data; pure storage/selection, full DATA_W preserved.

## Timing
- Latency 1: accepted sample at edge n → out_valid=1 after edge n+1, window includes that sample as tap 0.
- Back-to-back samples, including same channel every cycle: each produces a window; no bubbles.
- out_taps/out_ch/out_primed are registered and hold their last value when out_valid=0.
- Reset values: out_valid=0, out_ch=0, out_taps=0, out_primed=0; all rings, wp, fc = 0.
- Reset asserted mid-stream: immediate async return to reset values; first post-reset sample on any channel yields a window of {x,0,0,…}, out_primed=0.

## Structure
- Shared package fir_pkg: DATA_W default, TAPS default, CH default, and a constant function for CH_W and wrap-safe modular decrement.
- Sub-module fir_tap_ring: one channel's ring (storage, wp, fc, age-ordered window output), instantiated CH times. Top-level holds channel demux, output mux and output registers.

## Test plan
- Reset/fill, defaults (TAPS=5, CH=1): feed 1,2,3 → windows {1,0,0,0,0}, {2,1,0,0,0}, {3,2,1,0,0}; out_primed=0 throughout.
- Wrap, defaults: feed 1..12 continuously → after 12, window {12,11,10,9,8}; out_primed=1 from the 5th sample on, with no glitch at the pointer wrap 4→0.
- Interleave, CH=3: feed ch0:10, ch1:20, ch0:11, ch2:30, ch0:12 → ch0 windows {10,0..}, {11,10,0..}, {12,11,10,0,0}; ch1/ch2 unaffected; out_ch matches input channel each cycle.
- Clear collision: prime ch0 with 1..5, then drive clear=1 with in_valid=1, data=99 → no out_valid, no state; next sample 7 → {7,0,0,0,0}, out_primed=0.
- Invalid channel, CH=3: in_ch=3 with in_valid=1 → out_valid stays 0, all rings unchanged.
- Async reset mid-stream, TAPS=7, DATA_W=12: after 9 samples, pulse rst_n low between edges → outputs 0 immediately; next sample 0xABC → {0xABC,0,…}.
